judge_window_ctrl: RTL

Multi-track hit-judgement controller with timing windows, the next generation of the two-track judgement logic. It sits between the note scroller (LCD side, which flags note arrival at the hit line), the debounced play buttons, and the piezo/score blocks. For each of `N_TRACK` tracks it grades each note as Perfect, Good or Miss from the press latency in 1 ms ticks. It serialises simultaneous results, holds the displayed grade for a fixed time, and gates a per-track tone for a fixed duration.

---
 rtl/judge_window_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/judge_window_ctrl.sv
// Multi-track hit-judgement controller: per-track timing windows grade presses,
// a fixed-priority arbiter serialises results, and display/tone timers follow each strobe.
module judge_window_ctrl #(
    parameter int N_TRACK    = 4,
    parameter int PERFECT_MS = 30,
    parameter int GOOD_MS    = 80,
    parameter int HOLD_MS    = 300,
    parameter int TONE_MS    = 150,
    parameter int CNT_W      = 32,
    parameter logic [N_TRACK*CNT_W-1:0] TONE_TABLE =
        {32'd71586, 32'd75843, 32'd85131, 32'd95555},
    localparam int TW = (N_TRACK > 1) ? $clog2(N_TRACK) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic [N_TRACK-1:0] i_note_arrive,
    input  logic [N_TRACK-1:0] i_btn_play,
    output logic               o_judge_valid,
    output logic [1:0]         o_judge,
    output logic [TW-1:0]      o_judge_track,
    output logic [1:0]         o_judge_disp,
    output logic               o_stray,
    output logic               o_play_en,
    output logic [CNT_W-1:0]   o_cnt_limit
);

    localparam int AGE_W  = $clog2(GOOD_MS + 2);
    localparam int HOLD_W = $clog2(HOLD_MS + 1);
    localparam int TONE_W = $clog2(TONE_MS + 1);

    localparam logic [AGE_W-1:0]  AGE_PERFECT = AGE_W'(PERFECT_MS);
    localparam logic [AGE_W-1:0]  AGE_GOOD    = AGE_W'(GOOD_MS);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_MS);
    localparam logic [TONE_W-1:0] TONE_LOAD   = TONE_W'(TONE_MS);

    localparam logic [1:0] G_PERFECT = 2'b11;
    localparam logic [1:0] G_GOOD    = 2'b10;
    localparam logic [1:0] G_MISS    = 2'b01;

    typedef enum logic {IDLE, OPEN} trk_state_t;

    trk_state_t       state_q [N_TRACK];
    trk_state_t       state_d [N_TRACK];
    logic [AGE_W-1:0] age_q   [N_TRACK];
    logic [AGE_W-1:0] age_d   [N_TRACK];

    logic [N_TRACK-1:0] res_vld;
    logic [1:0]         res_grade [N_TRACK];
    logic [N_TRACK-1:0] stray_req;

    logic [N_TRACK-1:0] pend_vld_q, pend_vld_d;
    logic [1:0]         pend_grade_q [N_TRACK];
    logic [1:0]         pend_grade_d [N_TRACK];

    logic [N_TRACK-1:0] grant;
    logic               sel_vld;
    logic [TW-1:0]      sel_track;
    logic [1:0]         sel_grade;

    logic               judge_valid_q, judge_valid_d;
    logic [1:0]         judge_q, judge_d;
    logic [TW-1:0]      judge_track_q, judge_track_d;
    logic [1:0]         disp_q, disp_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               stray_q, stray_d;
    logic               play_en_q, play_en_d;
    logic [TONE_W-1:0]  tone_q, tone_d;
    logic [CNT_W-1:0]   limit_q, limit_d;

    // Per-track window FSM and grading; an arrive is handled before a same-cycle press.
    always_comb begin
        for (int k = 0; k < N_TRACK; k++) begin
            state_d[k]   = state_q[k];
            age_d[k]     = age_q[k];
            res_vld[k]   = 1'b0;
            res_grade[k] = 2'b00;
            stray_req[k] = 1'b0;
            case (state_q[k])
                IDLE: begin
                    if (i_note_arrive[k]) begin
                        state_d[k] = OPEN;
                        age_d[k]   = '0;
                        if (i_btn_play[k]) begin
                            res_vld[k]   = 1'b1;
                            res_grade[k] = G_PERFECT;
                            state_d[k]   = IDLE;
                        end
                    end else if (i_btn_play[k]) begin
                        stray_req[k] = 1'b1;
                    end
                end
                OPEN: begin
                    if (i_note_arrive[k]) begin
                        res_vld[k]   = 1'b1;
                        res_grade[k] = G_MISS;
                        age_d[k]     = '0;
                        if (i_btn_play[k]) begin
                            res_grade[k] = G_PERFECT;
                            state_d[k]   = IDLE;
                        end
                    end else if (i_btn_play[k]) begin
                        res_vld[k]   = 1'b1;
                        res_grade[k] = (age_q[k] <= AGE_PERFECT) ? G_PERFECT : G_GOOD;
                        state_d[k]   = IDLE;
                    end else if (i_tick) begin
                        if (age_q[k] >= AGE_GOOD) begin
                            res_vld[k]   = 1'b1;
                            res_grade[k] = G_MISS;
                            state_d[k]   = IDLE;
                            age_d[k]     = '0;
                        end else begin
                            age_d[k] = age_q[k] + 1'b1;
                        end
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    // Lowest-index pending result wins the output slot this cycle.
    always_comb begin
        grant     = '0;
        sel_vld   = 1'b0;
        sel_track = '0;
        sel_grade = 2'b00;
        for (int k = 0; k < N_TRACK; k++) begin
            if (!sel_vld && pend_vld_q[k]) begin
                grant[k]  = 1'b1;
                sel_vld   = 1'b1;
                sel_track = TW'(k);
                sel_grade = pend_grade_q[k];
            end
        end
    end

    // A fresh result overwrites whatever is still waiting in the slot.
    always_comb begin
        for (int k = 0; k < N_TRACK; k++) begin
            pend_vld_d[k]   = pend_vld_q[k] & ~grant[k];
            pend_grade_d[k] = pend_grade_q[k];
            if (res_vld[k]) begin
                pend_vld_d[k]   = 1'b1;
                pend_grade_d[k] = res_grade[k];
            end
        end
    end

    always_comb begin
        judge_valid_d = sel_vld;
        judge_d       = sel_vld ? sel_grade : 2'b00;
        judge_track_d = sel_vld ? sel_track : '0;
        stray_d       = |stray_req;

        disp_d = disp_q;
        hold_d = hold_q;
        if (sel_vld) begin
            disp_d = sel_grade;
            hold_d = HOLD_LOAD;
        end else if (i_tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) begin
                disp_d = 2'b00;
            end
        end

        // Only Perfect/Good (grade bit 1 set) touch the tone; a Miss lets it run on.
        play_en_d = play_en_q;
        tone_d    = tone_q;
        limit_d   = limit_q;
        if (sel_vld && sel_grade[1]) begin
            play_en_d = 1'b1;
            tone_d    = TONE_LOAD;
            limit_d   = TONE_TABLE[sel_track*CNT_W +: CNT_W];
        end else if (i_tick && (tone_q != '0)) begin
            tone_d = tone_q - 1'b1;
            if (tone_q == TONE_W'(1)) begin
                play_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TRACK; k++) begin
                state_q[k]      <= IDLE;
                age_q[k]        <= '0;
                pend_grade_q[k] <= 2'b00;
            end
            pend_vld_q    <= '0;
            judge_valid_q <= 1'b0;
            judge_q       <= 2'b00;
            judge_track_q <= '0;
            disp_q        <= 2'b00;
            hold_q        <= '0;
            stray_q       <= 1'b0;
            play_en_q     <= 1'b0;
            tone_q        <= '0;
            limit_q       <= '0;
        end else begin
            for (int k = 0; k < N_TRACK; k++) begin
                state_q[k]      <= state_d[k];
                age_q[k]        <= age_d[k];
                pend_grade_q[k] <= pend_grade_d[k];
            end
            pend_vld_q    <= pend_vld_d;
            judge_valid_q <= judge_valid_d;
            judge_q       <= judge_d;
            judge_track_q <= judge_track_d;
            disp_q        <= disp_d;
            hold_q        <= hold_d;
            stray_q       <= stray_d;
            play_en_q     <= play_en_d;
            tone_q        <= tone_d;
            limit_q       <= limit_d;
        end
    end

    assign o_judge_valid = judge_valid_q;
    assign o_judge       = judge_q;
    assign o_judge_track = judge_track_q;
    assign o_judge_disp  = disp_q;
    assign o_stray       = stray_q;
    assign o_play_en     = play_en_q;
    assign o_cnt_limit   = limit_q;

endmodule
